// File: rtl/core_pkg.sv
// Shared core types for the writeback path: the register-file result record
// and the architectural register count.
package core_pkg;

  localparam int REG_COUNT = 32;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_result_t;

  // One-hot decode of a destination register into a pending-mask vector.
  function automatic logic [REG_COUNT-1:0] rd_onehot(input logic [4:0] rd);
    logic [REG_COUNT-1:0] mask;
    mask = '0;
    mask[rd] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result buffer for the writeback arbiter. Holds DEPTH results
// in arrival order and reports which destination registers are still waiting.
// The owner must only push when count < DEPTH and only pop when count > 0;
// out-of-range requests are ignored so the pointers can never slip.
module wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  wb_result_t                   push_data_i,
  input  logic                         pop_i,
  output wb_result_t                   head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [REG_COUNT-1:0]         pending_mask_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  wb_result_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && (count_o != FULL_COUNT);
  assign pop_ok  = pop_i && (count_o != '0);
  assign head_o  = mem[rd_ptr];

  // Storage needs no reset: only entries covered by count are ever observed.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_o <= count_o + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_o <= count_o - 1'b1;
      end
    end
  end

  // Walk the occupied window from the head and flag each buffered destination.
  always_comb begin
    pending_mask_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count_o) begin
        pending_mask_o = pending_mask_o | rd_onehot(mem[rd_ptr + PTR_W'(k)].rd);
      end
    end
    pending_mask_o[0] = 1'b0;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter. Merges the in-order pipeline result stream
// with a buffered long-latency stream onto one registered write port. The
// pipeline normally has priority; long-latency results wait in wb_fifo.
// Optional feature macro: WB_STARVE_GUARD_EN adds a head-age counter that
// stalls the pipeline for one cycle once the FIFO head has waited
// STARVE_LIMIT cycles, guaranteeing forward progress for buffered results.
module writeback_arbiter
  import core_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 pipe_valid_i,
  input  logic [4:0]           pipe_rd_i,
  input  logic [31:0]          pipe_data_i,
  output logic                 pipe_ready_o,
  input  logic                 lu_valid_i,
  input  logic [4:0]           lu_rd_i,
  input  logic [31:0]          lu_data_i,
  output logic                 lu_ready_o,
  output logic [4:0]           write_register_o,
  output logic [31:0]          write_back_data_o,
  output logic                 ctrl_write_back_o,
  output logic [REG_COUNT-1:0] pending_mask_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (STARVE_LIMIT < 1)) begin : g_param_check
    $error("writeback_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  wb_result_t       head;
  wb_result_t       lu_result;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             ready_en;
  logic             starve_hit;
  logic             pipe_fire;
  logic             pipe_write;
  logic             lu_push;
  logic             fifo_pop;

  assign fifo_empty   = (fifo_count == '0);
  assign pipe_ready_o = ready_en && !starve_hit;
  assign lu_ready_o   = ready_en && (fifo_count < FULL_COUNT);
  assign pipe_fire    = pipe_valid_i && pipe_ready_o;
  assign pipe_write   = pipe_fire && (pipe_rd_i != 5'd0);
  assign lu_push      = lu_valid_i && lu_ready_o && (lu_rd_i != 5'd0);
  assign fifo_pop     = !fifo_empty && !pipe_write;
  assign lu_result    = '{rd: lu_rd_i, data: lu_data_i};

  // Hold both ready outputs low through reset and release them on the first edge after.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] head_age;

  // Count how long the current head has been passed over; reset whenever it leaves.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_age <= '0;
    end else if (fifo_empty || fifo_pop) begin
      head_age <= '0;
    end else begin
      head_age <= head_age + 1'b1;
    end
  end

  assign starve_hit = !fifo_empty && (head_age == AGE_LIMIT);
`else
  assign starve_hit = 1'b0;
`endif

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .push_i        (lu_push),
    .push_data_i   (lu_result),
    .pop_i         (fifo_pop),
    .head_o        (head),
    .count_o       (fifo_count),
    .pending_mask_o(pending_mask_o)
  );

  // Register the selected result; an idle cycle drops the enable but keeps reg/data stable.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ctrl_write_back_o <= 1'b0;
      write_register_o  <= '0;
      write_back_data_o <= '0;
    end else if (pipe_write) begin
      ctrl_write_back_o <= 1'b1;
      write_register_o  <= pipe_rd_i;
      write_back_data_o <= pipe_data_i;
    end else if (fifo_pop) begin
      ctrl_write_back_o <= 1'b1;
      write_register_o  <= head.rd;
      write_back_data_o <= head.data;
    end else begin
      ctrl_write_back_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with default DEPTH=2, STARVE_LIMIT=8.
// Build with WB_STARVE_GUARD_EN defined to exercise the starvation guard.
module tb_writeback_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        pipe_valid_i = 1'b0;
  logic [4:0]  pipe_rd_i = '0;
  logic [31:0] pipe_data_i = '0;
  logic        pipe_ready_o;
  logic        lu_valid_i = 1'b0;
  logic [4:0]  lu_rd_i = '0;
  logic [31:0] lu_data_i = '0;
  logic        lu_ready_o;
  logic [4:0]  write_register_o;
  logic [31:0] write_back_data_o;
  logic        ctrl_write_back_o;
  logic [31:0] pending_mask_o;

  int total = 0;
  int bad = 0;

  writeback_arbiter #(
    .DEPTH(2),
    .STARVE_LIMIT(8)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .pipe_valid_i     (pipe_valid_i),
    .pipe_rd_i        (pipe_rd_i),
    .pipe_data_i      (pipe_data_i),
    .pipe_ready_o     (pipe_ready_o),
    .lu_valid_i       (lu_valid_i),
    .lu_rd_i          (lu_rd_i),
    .lu_data_i        (lu_data_i),
    .lu_ready_o       (lu_ready_o),
    .write_register_o (write_register_o),
    .write_back_data_o(write_back_data_o),
    .ctrl_write_back_o(ctrl_write_back_o),
    .pending_mask_o   (pending_mask_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid_i = 1'b0;
    pipe_rd_i    = '0;
    pipe_data_i  = '0;
    lu_valid_i   = 1'b0;
    lu_rd_i      = '0;
    lu_data_i    = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if ({ctrl_write_back_o, write_register_o, write_back_data_o} !== 38'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got wb=%0b rd=%0d data=%h, want 0/0/0", ctrl_write_back_o, write_register_o, write_back_data_o);
    end
    total++;
    if ({pipe_ready_o, lu_ready_o} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_ready: got pipe=%0b lu=%0b, want 0 0", pipe_ready_o, lu_ready_o);
    end
    total++;
    if (pending_mask_o !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_mask: got %h, want 0", pending_mask_o);
    end
    reset_i = 1'b0;
    #1;
    total++;
    if ({pipe_ready_o, lu_ready_o} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL ready_before_edge: got pipe=%0b lu=%0b, want 0 0", pipe_ready_o, lu_ready_o);
    end
    tick();
    total++;
    if ({pipe_ready_o, lu_ready_o} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL ready_after_release: got pipe=%0b lu=%0b, want 1 1", pipe_ready_o, lu_ready_o);
    end
  endtask

  task automatic test_lu_single();
    lu_valid_i = 1'b1;
    lu_rd_i    = 5'd5;
    lu_data_i  = 32'hDEADBEEF;
    tick();
    idle_inputs();
    total++;
    if (pending_mask_o !== 32'h0000_0020 || ctrl_write_back_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL lu_pending: got mask=%h wb=%0b, want 00000020 0", pending_mask_o, ctrl_write_back_o);
    end
    tick();
    total++;
    if ({ctrl_write_back_o, write_register_o, write_back_data_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      bad++;
      $display("[TB] FAIL lu_write: got wb=%0b rd=%0d data=%h, want 1/5/deadbeef", ctrl_write_back_o, write_register_o, write_back_data_o);
    end
    total++;
    if (pending_mask_o !== 32'd0) begin
      bad++;
      $display("[TB] FAIL lu_mask_clear: got %h, want 0", pending_mask_o);
    end
    tick();
    total++;
    if (ctrl_write_back_o !== 1'b0 || write_back_data_o !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL idle_hold: got wb=%0b data=%h, want 0 deadbeef", ctrl_write_back_o, write_back_data_o);
    end
  endtask

  task automatic test_lu_rd0();
    lu_valid_i = 1'b1;
    lu_rd_i    = 5'd0;
    lu_data_i  = 32'h1234_5678;
    total++;
    if (lu_ready_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL lu_rd0_ready: got %0b, want 1", lu_ready_o);
    end
    tick();
    idle_inputs();
    total++;
    if (pending_mask_o !== 32'd0) begin
      bad++;
      $display("[TB] FAIL lu_rd0_mask: got %h, want 0", pending_mask_o);
    end
    tick();
    total++;
    if (ctrl_write_back_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL lu_rd0_discard: got wb=%0b, want 0", ctrl_write_back_o);
    end
  endtask

  task automatic test_same_cycle();
    pipe_valid_i = 1'b1;
    pipe_rd_i    = 5'd3;
    pipe_data_i  = 32'h11;
    lu_valid_i   = 1'b1;
    lu_rd_i      = 5'd4;
    lu_data_i    = 32'h22;
    tick();
    idle_inputs();
    total++;
    if ({ctrl_write_back_o, write_register_o, write_back_data_o} !== {1'b1, 5'd3, 32'h11}) begin
      bad++;
      $display("[TB] FAIL same_first: got wb=%0b rd=%0d data=%h, want 1/3/11", ctrl_write_back_o, write_register_o, write_back_data_o);
    end
    total++;
    if (pending_mask_o !== 32'h0000_0010) begin
      bad++;
      $display("[TB] FAIL same_mask: got %h, want 00000010", pending_mask_o);
    end
    tick();
    total++;
    if ({ctrl_write_back_o, write_register_o, write_back_data_o} !== {1'b1, 5'd4, 32'h22}) begin
      bad++;
      $display("[TB] FAIL same_second: got wb=%0b rd=%0d data=%h, want 1/4/22", ctrl_write_back_o, write_register_o, write_back_data_o);
    end
    tick();
    total++;
    if (ctrl_write_back_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL same_idle: got wb=%0b, want 0", ctrl_write_back_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  lu_rds [3]   = '{5'd10, 5'd11, 5'd12};
    logic [31:0] lu_dats [3]  = '{32'hA0, 32'hB0, 32'hC0};
    logic        ready_exp [3] = '{1'b1, 1'b1, 1'b0};
    // Pipe writes rd1 every cycle while three LU results arrive; the third must stall.
    for (int i = 0; i < 3; i++) begin
      pipe_valid_i = 1'b1;
      pipe_rd_i    = 5'd1;
      pipe_data_i  = 32'h100 + i;
      lu_valid_i   = 1'b1;
      lu_rd_i      = lu_rds[i];
      lu_data_i    = lu_dats[i];
      #1;
      total++;
      if (lu_ready_o !== ready_exp[i]) begin
        bad++;
        $display("[TB] FAIL b2b_lu_ready%0d: got %0b, want %0b", i, lu_ready_o, ready_exp[i]);
      end
      tick();
      total++;
      if ({ctrl_write_back_o, write_register_o, write_back_data_o} !== {1'b1, 5'd1, 32'h100 + i}) begin
        bad++;
        $display("[TB] FAIL b2b_pipe%0d: got wb=%0b rd=%0d data=%h, want 1/1/%h", i, ctrl_write_back_o, write_register_o, write_back_data_o, 32'h100 + i);
      end
    end
    total++;
    if (pending_mask_o !== 32'h0000_0C00) begin
      bad++;
      $display("[TB] FAIL b2b_full_mask: got %h, want 00000c00", pending_mask_o);
    end
    // Pipe goes idle; rd12 is still offered and enters once a slot frees.
    pipe_valid_i = 1'b0;
    pipe_rd_i    = '0;
    tick();
    total++;
    if ({ctrl_write_back_o, write_register_o, write_back_data_o} !== {1'b1, 5'd10, 32'hA0}) begin
      bad++;
      $display("[TB] FAIL b2b_drain0: got wb=%0b rd=%0d data=%h, want 1/10/a0", ctrl_write_back_o, write_register_o, write_back_data_o);
    end
    total++;
    if (lu_ready_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_ready_free: got %0b, want 1", lu_ready_o);
    end
    tick();
    idle_inputs();
    total++;
    if ({ctrl_write_back_o, write_register_o, write_back_data_o} !== {1'b1, 5'd11, 32'hB0}) begin
      bad++;
      $display("[TB] FAIL b2b_drain1: got wb=%0b rd=%0d data=%h, want 1/11/b0", ctrl_write_back_o, write_register_o, write_back_data_o);
    end
    tick();
    total++;
    if ({ctrl_write_back_o, write_register_o, write_back_data_o} !== {1'b1, 5'd12, 32'hC0}) begin
      bad++;
      $display("[TB] FAIL b2b_drain2: got wb=%0b rd=%0d data=%h, want 1/12/c0", ctrl_write_back_o, write_register_o, write_back_data_o);
    end
    tick();
    total++;
    if (ctrl_write_back_o !== 1'b0 || pending_mask_o !== 32'd0) begin
      bad++;
      $display("[TB] FAIL b2b_empty: got wb=%0b mask=%h, want 0 0", ctrl_write_back_o, pending_mask_o);
    end
  endtask

  task automatic test_pipe_rd0();
    int rd0_writes = 0;
    pipe_valid_i = 1'b1;
    pipe_rd_i    = 5'd1;
    pipe_data_i  = 32'h200;
    lu_valid_i   = 1'b1;
    lu_rd_i      = 5'd7;
    lu_data_i    = 32'h77;
    tick();
    lu_valid_i  = 1'b0;
    pipe_rd_i   = 5'd0;
    pipe_data_i = 32'h999;
    total++;
    if (pipe_ready_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rd0_pipe_ready: got %0b, want 1", pipe_ready_o);
    end
    tick();
    if (ctrl_write_back_o === 1'b1 && write_register_o === 5'd0) rd0_writes++;
    total++;
    if ({ctrl_write_back_o, write_register_o, write_back_data_o} !== {1'b1, 5'd7, 32'h77}) begin
      bad++;
      $display("[TB] FAIL rd0_pop: got wb=%0b rd=%0d data=%h, want 1/7/77", ctrl_write_back_o, write_register_o, write_back_data_o);
    end
    tick();
    if (ctrl_write_back_o === 1'b1 && write_register_o === 5'd0) rd0_writes++;
    idle_inputs();
    tick();
    if (ctrl_write_back_o === 1'b1 && write_register_o === 5'd0) rd0_writes++;
    total++;
    if (rd0_writes !== 0) begin
      bad++;
      $display("[TB] FAIL rd0_never_written: got %0d writes, want 0", rd0_writes);
    end
  endtask

  task automatic test_starvation();
`ifdef WB_STARVE_GUARD_EN
    localparam int STALL_AT = 9;
`else
    localparam int STALL_AT = -1;
`endif
    for (int i = 0; i < 12; i++) begin
      pipe_valid_i = 1'b1;
      pipe_rd_i    = 5'd2;
      pipe_data_i  = 32'h300 + i;
      lu_valid_i   = (i == 0);
      lu_rd_i      = 5'd9;
      lu_data_i    = 32'h99;
      #1;
      total++;
      if (pipe_ready_o !== (i != STALL_AT)) begin
        bad++;
        $display("[TB] FAIL starve_ready%0d: got %0b, want %0b", i, pipe_ready_o, (i != STALL_AT));
      end
      tick();
      if (i == STALL_AT) begin
        total++;
        if ({ctrl_write_back_o, write_register_o, write_back_data_o} !== {1'b1, 5'd9, 32'h99}) begin
          bad++;
          $display("[TB] FAIL starve_pop: got wb=%0b rd=%0d data=%h, want 1/9/99", ctrl_write_back_o, write_register_o, write_back_data_o);
        end
      end else begin
        total++;
        if ({ctrl_write_back_o, write_register_o, write_back_data_o} !== {1'b1, 5'd2, 32'h300 + i}) begin
          bad++;
          $display("[TB] FAIL starve_pipe%0d: got wb=%0b rd=%0d data=%h, want 1/2/%h", i, ctrl_write_back_o, write_register_o, write_back_data_o, 32'h300 + i);
        end
      end
    end
    idle_inputs();
    tick();
    total++;
    if (ctrl_write_back_o !== (STALL_AT < 0) || (STALL_AT < 0 && write_register_o !== 5'd9)) begin
      bad++;
      $display("[TB] FAIL starve_final: got wb=%0b rd=%0d, want wb=%0b", ctrl_write_back_o, write_register_o, (STALL_AT < 0));
    end
    tick();
    total++;
    if (ctrl_write_back_o !== 1'b0 || pending_mask_o !== 32'd0) begin
      bad++;
      $display("[TB] FAIL starve_empty: got wb=%0b mask=%h, want 0 0", ctrl_write_back_o, pending_mask_o);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      pipe_valid_i = 1'b1;
      pipe_rd_i    = 5'd1;
      pipe_data_i  = 32'h400 + i;
      lu_valid_i   = 1'b1;
      lu_rd_i      = 5'd20 + 5'(i);
      lu_data_i    = 32'h500 + i;
      tick();
    end
    idle_inputs();
    pipe_valid_i = 1'b1;
    pipe_rd_i    = 5'd1;
    #1;
    total++;
    if (pending_mask_o !== 32'h0030_0000 || lu_ready_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_full: got mask=%h lu_ready=%0b, want 00300000 0", pending_mask_o, lu_ready_o);
    end
    #1;
    reset_i = 1'b1;
    #1;
    total++;
    if ({ctrl_write_back_o, write_register_o, write_back_data_o, pending_mask_o} !== 70'd0) begin
      bad++;
      $display("[TB] FAIL mid_async: got wb=%0b rd=%0d data=%h mask=%h, want all 0", ctrl_write_back_o, write_register_o, write_back_data_o, pending_mask_o);
    end
    total++;
    if ({pipe_ready_o, lu_ready_o} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL mid_ready: got pipe=%0b lu=%0b, want 0 0", pipe_ready_o, lu_ready_o);
    end
    idle_inputs();
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (ctrl_write_back_o !== 1'b0 || pending_mask_o !== 32'd0) begin
        bad++;
        $display("[TB] FAIL mid_no_write%0d: got wb=%0b mask=%h, want 0 0", i, ctrl_write_back_o, pending_mask_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lu_single();
    test_lu_rd0();
    test_same_cycle();
    test_back_to_back();
    test_pipe_rd0();
    test_starvation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, long-latency result FIFO entries (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, default 8, head-age threshold for starvation guard.
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 reset_i  in  1  reset, asynchronous, active-high.
REQ-005 pipe_valid_i/pipe_rd_i/pipe_data_i  in  1/5/32  in-order pipeline result.
REQ-006 pipe_ready_o  out  1  pipeline result accepted this cycle.
REQ-007 lu_valid_i/lu_rd_i/lu_data_i  in  1/5/32  long-latency unit (load/mul/div) result.
REQ-008 lu_ready_o  out  1  long-latency result accepted this cycle.
REQ-009 write_register_o/write_back_data_o/ctrl_write_back_o  out  5/32/1  register-file write port.
REQ-010 pending_mask_o  out  32  bit n set while any FIFO entry targets rd n.

Function
REQ-011 Pipe transfer on pipe_valid_i & pipe_ready_o; LU transfer on lu_valid_i & lu_ready_o.
REQ-012 lu_ready_o SHALL equal (count < DEPTH) from registered count only; no push-through-when-full, even with same-cycle pop.
REQ-013 LU transfer with lu_rd_i==0 SHALL be accepted and discarded, not stored.
REQ-014 Write-port outputs SHALL be registered: selected result appears exactly one cycle after selection.
REQ-015 Selection per cycle: pipe transfer with rd!=0 wins; else FIFO head pops if count>0; else ctrl_write_back_o=0 next cycle.
REQ-016 Pipe transfer with rd==0 SHALL be consumed and SHALL NOT block a FIFO pop that cycle.
REQ-017 Without guard (REQ-025 off), pipe_ready_o SHALL be constant 1.
REQ-018 FIFO SHALL pop in push order; pointers wrap modulo DEPTH.
REQ-019 Push and pop in same cycle (count<DEPTH) SHALL leave count unchanged.
REQ-020 pending_mask_o SHALL be combinational from valid FIFO entries; bit 0 always 0; entry's bit clears the cycle after its pop.
REQ-021 When write_register_o is driven with ctrl_write_back_o=0, its value is don't-care; data held stable.

Reset
REQ-022 On reset_i high: count, pointers, head age = 0; ctrl_write_back_o=0, write_register_o=0, write_back_data_o=0; FIFO contents discarded.
REQ-023 During reset lu_ready_o=0, pipe_ready_o=0; both become valid on first edge after deassertion.
REQ-024 Reset mid-operation SHALL drop all buffered results with no write issued.

Configuration
REQ-025 Macro WB_STARVE_GUARD_EN: when defined, head-age counter increments each cycle head is non-empty and not popped, clears on pop; at age==STARVE_LIMIT pipe_ready_o=0 and head pops that cycle.
REQ-026 Without WB_STARVE_GUARD_EN no age counter exists; FIFO may starve indefinitely under continuous pipe writes.

Structure
REQ-027 Shared package core_pkg SHALL hold typedef wb_result_t {rd[4:0], data[31:0]} and constant REG_COUNT=32.
REQ-028 One sub-module wb_fifo (DEPTH-entry wb_result_t FIFO, count, pending mask) SHALL be instantiated; arbitration, output registers, age counter stay in top.

Verification
REQ-029 LU push rd=5 data=0xDEADBEEF, pipe idle -> cycle+2: ctrl_write_back_o=1, rd=5, data=0xDEADBEEF; pending_mask_o bit5 high exactly 1 cycle.
REQ-030 Pipe rd=3 data=0x11 and LU rd=4 data=0x22 same cycle -> writes rd3 then rd4 on consecutive cycles.
REQ-031 Pipe continuous rd=1 writes, 3 LU pushes (DEPTH=2) -> lu_ready_o low after 2; drains in order once pipe idles; no lost/duplicated writes.
REQ-032 Pipe rd=0 valid while FIFO holds rd=7 -> rd7 written next cycle, no write to rd0 ever.
REQ-033 Guard on, STARVE_LIMIT=8, pipe valid every cycle, one LU entry -> pipe_ready_o low exactly one cycle at age 8, LU entry written next.
REQ-034 reset_i asserted with count=2 mid-cycle -> outputs 0 immediately, no write after deassertion, pending_mask_o=0.
